// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and helpers for the packet-aware PCIe TX arbiter.
package pcie_tx_arb_pkg;

  localparam int MAX_NUM_PORTS = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // MAX_PKTS=0 disables the limit; the counter still needs one bit to exist.
  function automatic int pkt_cnt_width(input int max_pkts);
    return (max_pkts == 0) ? 1 : $clog2(max_pkts + 1);
  endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// Rotating priority encoder: first set req bit searching upward from last_grant+1.
module pcie_rr_pick
  import pcie_tx_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  int p;

  // Scan from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    p     = 0;
    for (int i = N; i >= 1; i--) begin
      p = (int'(last_grant) + i) % N;
      if (req[p]) begin
        valid = 1'b1;
        index = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// N-port round-robin arbiter for the shared AXIS TX port; grants are held across whole TLPs.
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int NUM_PORTS    = 4,
  parameter int MAX_PKTS     = 8,
  parameter int TCQ          = 1
) (
  input  logic                               clk,
  input  logic                               sys_rst,
  input  logic                               s_axis_tx_tready,
  output logic [C_DATA_WIDTH-1:0]            s_axis_tx_tdata,
  output logic [KEEP_WIDTH-1:0]              s_axis_tx_tkeep,
  output logic                               s_axis_tx_tlast,
  output logic                               s_axis_tx_tvalid,
  output logic                               tx_src_dsc,
  input  logic [NUM_PORTS-1:0]               req,
  output logic [NUM_PORTS-1:0]               ack,
  output logic [NUM_PORTS-1:0]               in_tready,
  input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]  in_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]    in_tkeep,
  input  logic [NUM_PORTS-1:0]               in_tlast,
  input  logic [NUM_PORTS-1:0]               in_tvalid,
  input  logic [NUM_PORTS-1:0]               in_src_dsc,
  output logic                               arb_err
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = pkt_cnt_width(MAX_PKTS);
  localparam logic [CNT_W-1:0] CNT_LAST = (MAX_PKTS == 0) ? '0 : CNT_W'(MAX_PKTS - 1);

  // TCQ exists only for drop-in compatibility with older instantiations; RTL has no delays.
  if (NUM_PORTS < 2 || NUM_PORTS > MAX_NUM_PORTS || TCQ < 0) begin : g_param_chk
    $error("pcie_tx_arbiter: illegal parameter value");
  end

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic                 in_pkt_q, in_pkt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic                 granted;
  logic                 beat;
  logic                 last_beat;

  pcie_rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .last_grant (gnt_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign granted = (state_q == ST_GRANT);

  always_comb begin
    s_axis_tx_tdata  = '0;
    s_axis_tx_tkeep  = '0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    tx_src_dsc       = 1'b0;
    if (granted) begin
      s_axis_tx_tdata  = in_tdata[int'(gnt_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
      s_axis_tx_tkeep  = in_tkeep[int'(gnt_q)*KEEP_WIDTH +: KEEP_WIDTH];
      s_axis_tx_tlast  = in_tlast[gnt_q];
      s_axis_tx_tvalid = in_tvalid[gnt_q];
      tx_src_dsc       = in_src_dsc[gnt_q];
    end
  end

  assign in_tready = {NUM_PORTS{s_axis_tx_tready}} & ack_q;
  assign ack       = ack_q;
  assign arb_err   = err_q;
  assign beat      = s_axis_tx_tvalid & s_axis_tx_tready;
  assign last_beat = beat & s_axis_tx_tlast;

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    gnt_d    = gnt_q;
    in_pkt_d = in_pkt_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_GRANT;
          ack_d           = '0;
          ack_d[pick_idx] = 1'b1;
          gnt_d           = pick_idx;
        end
      end
      ST_GRANT: begin
        if (beat) in_pkt_d = ~s_axis_tx_tlast;
        if (last_beat && MAX_PKTS != 0) cnt_d = cnt_q + CNT_W'(1);
        // Requester gave up mid-TLP: keep the grant so the packet still completes.
        if (!req[gnt_q] && in_pkt_q) err_d = 1'b1;
        if ((!req[gnt_q] && !in_pkt_q && !beat) ||
            (MAX_PKTS != 0 && last_beat && cnt_q == CNT_LAST)) begin
          state_d = ST_IDLE;
          ack_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      ack_q    <= '0;
      gnt_q    <= IDX_W'(NUM_PORTS - 1);
      in_pkt_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      gnt_q    <= gnt_d;
      in_pkt_q <= in_pkt_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule
